// File: rtl/usrt_apb_ctrl.sv
// rtl/usrt_apb_ctrl.sv - APB register front end for the USRT serializer/deserializer and baud generator
module usrt_apb_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  BAUD_RST = 8'd15
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSelect,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [ADDR_W-1:0] pAddress,
    input  logic [7:0]        pWData,
    output logic [7:0]        pRData,
    output logic              pReady,
    output logic              baud_tick,
    output logic              tx_start,
    output logic [10:0]       tx_frame,
    input  logic              tx_done,
    output logic              rx_en,
    input  logic              rx_valid,
    input  logic [10:0]       rx_frame,
    output logic              irq
);

    typedef enum logic [1:0] {T_IDLE, T_START, T_BUSY} txState_t;

    txState_t    state, nextState;
    logic [5:0]  ctrl;
    logic [7:0]  baud, cnt, thr, rbr;
    logic        thrFull, rxValid, rxOvr, parErr, frmErr, txOvf;
    logic        access, wrData, rdData, wrStatus, wrCtrl, wrBaud;
    logic        en, odd, txEn, txLoad, rxGo, rxTake, setOvr, setPar, setFrm;
    logic        thrEmpty, txIdle;
    logic        unusedAddr;

    assign unusedAddr = ^pAddress[ADDR_W-1:2];

    assign access   = pSelect & pEnable;
    assign pReady   = access;
    assign wrData   = access &  pWrite & (pAddress[1:0] == 2'd0);
    assign rdData   = access & ~pWrite & (pAddress[1:0] == 2'd0);
    assign wrStatus = access &  pWrite & (pAddress[1:0] == 2'd1);
    assign wrCtrl   = access &  pWrite & (pAddress[1:0] == 2'd2);
    assign wrBaud   = access &  pWrite & (pAddress[1:0] == 2'd3);

    assign en    = ctrl[0];
    assign odd   = ctrl[1];
    assign txEn  = ctrl[3];
    assign rx_en = en & ctrl[2];

    assign thrEmpty  = ~thrFull;
    assign txIdle    = (state == T_IDLE) & ~thrFull;
    assign baud_tick = en & ~wrBaud & (cnt == baud);

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            cnt <= 8'd0;
        end else if (!en || wrBaud || cnt == baud) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        nextState = state;
        tx_start  = 1'b0;
        txLoad    = 1'b0;
        case (state)
            T_IDLE: begin
                if (en && txEn && thrFull && baud_tick) begin
                    txLoad    = 1'b1;
                    nextState = T_START;
                end
            end
            T_START: begin
                tx_start  = 1'b1;
                nextState = (en && txEn) ? T_BUSY : T_IDLE;
            end
            T_BUSY: begin
                if (!(en && txEn) || tx_done) nextState = T_IDLE;
            end
            default: nextState = T_IDLE;
        endcase
    end

    // A frame is accepted when the holding register is free; a full one drops it as an overrun.
    assign rxGo   = rx_valid & rx_en;
    assign rxTake = rxGo & (~rxValid | rdData);
    assign setOvr = rxGo & rxValid & ~rdData;
    assign setPar = rxTake & (rx_frame[9] != (^rx_frame[8:1] ^ odd));
    assign setFrm = rxTake & (rx_frame[0] | ~rx_frame[10]);

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            state    <= T_IDLE;
            tx_frame <= 11'd0;
            thr      <= 8'd0;
            thrFull  <= 1'b0;
            rbr      <= 8'd0;
            rxValid  <= 1'b0;
            rxOvr    <= 1'b0;
            parErr   <= 1'b0;
            frmErr   <= 1'b0;
            txOvf    <= 1'b0;
            ctrl     <= 6'd0;
            baud     <= BAUD_RST;
            irq      <= 1'b0;
        end else begin
            state <= nextState;
            if (txLoad) tx_frame <= {1'b1, ^thr ^ odd, thr, 1'b0};

            if (wrData && (!thrFull || txLoad)) begin
                thr     <= pWData;
                thrFull <= 1'b1;
            end else if (txLoad) begin
                thrFull <= 1'b0;
            end

            if (rxTake) begin
                rbr     <= rx_frame[8:1];
                rxValid <= 1'b1;
            end else if (rdData) begin
                rxValid <= 1'b0;
            end

            // Set wins over a same-cycle write-one-to-clear.
            rxOvr  <= (rxOvr  & ~(wrStatus & pWData[3])) | setOvr;
            parErr <= (parErr & ~(wrStatus & pWData[4])) | setPar;
            frmErr <= (frmErr & ~(wrStatus & pWData[5])) | setFrm;
            txOvf  <= (txOvf  & ~(wrStatus & pWData[6])) | (wrData & thrFull & ~txLoad);

            if (wrCtrl) ctrl <= pWData[5:0];
            if (wrBaud) baud <= pWData;

            irq <= (ctrl[4] & rxValid) | (ctrl[5] & thrEmpty) | rxOvr | parErr | frmErr | txOvf;
        end
    end

    always_comb begin
        pRData = 8'd0;
        if (pSelect && !pWrite) begin
            case (pAddress[1:0])
                2'd0:    pRData = rbr;
                2'd1:    pRData = {1'b0, txOvf, frmErr, parErr, rxOvr, txIdle, thrEmpty, rxValid};
                2'd2:    pRData = {2'b00, ctrl};
                default: pRData = baud;
            endcase
        end
    end

endmodule

// File: tb/tb_usrt_apb_ctrl.sv
// tb/tb_usrt_apb_ctrl.sv - directed self-checking bench for usrt_apb_ctrl
module tb_usrt_apb_ctrl;

    logic        pClk = 1'b0;
    logic        pReset = 1'b1;
    logic        pSelect = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
    logic [7:0]  pAddress = 8'd0, pWData = 8'd0;
    logic [7:0]  pRData;
    logic        pReady, baud_tick, tx_start, tx_done = 1'b0, rx_en, rx_valid = 1'b0, irq;
    logic [10:0] tx_frame;
    logic [10:0] rx_frame = 11'd0;

    int nCompared = 0;
    int nMismatched = 0;

    usrt_apb_ctrl #(.ADDR_W(8), .BAUD_RST(8'd15)) dut (
        .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable),
        .pWrite(pWrite), .pAddress(pAddress), .pWData(pWData), .pRData(pRData),
        .pReady(pReady), .baud_tick(baud_tick), .tx_start(tx_start), .tx_frame(tx_frame),
        .tx_done(tx_done), .rx_en(rx_en), .rx_valid(rx_valid), .rx_frame(rx_frame), .irq(irq)
    );

    always #5 pClk = ~pClk;

    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apbWrite(input logic [7:0] addr, input logic [7:0] data);
        @(negedge pClk);
        pSelect = 1'b1; pWrite = 1'b1; pEnable = 1'b0; pAddress = addr; pWData = data;
        @(negedge pClk);
        pEnable = 1'b1;
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    endtask

    task automatic apbRead(input logic [7:0] addr, output logic [7:0] data);
        @(negedge pClk);
        pSelect = 1'b1; pWrite = 1'b0; pEnable = 1'b0; pAddress = addr;
        @(negedge pClk);
        pEnable = 1'b1;
        #1 data = pRData;
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0;
    endtask

    task automatic readExpect(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        apbRead(addr, d);
        expectEq(tag, d, exp);
    endtask

    task automatic waitTxStart(input string tag);
        logic seen, prevTick;
        seen = 1'b0;
        prevTick = baud_tick;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge pClk);
            if (tx_start) seen = 1'b1;
            else prevTick = baud_tick;
        end
        expectEq({tag, "_seen"}, seen, 1);
        expectEq({tag, "_after_tick"}, prevTick, 1);
    endtask

    task automatic pulseTxDone();
        @(negedge pClk); tx_done = 1'b1;
        @(negedge pClk); tx_done = 1'b0;
    endtask

    task automatic pulseRx(input logic [10:0] f);
        @(negedge pClk); rx_valid = 1'b1; rx_frame = f;
        @(negedge pClk); rx_valid = 1'b0;
    endtask

    task automatic measureBaud(input string tag, input int exp);
        int gap;
        logic found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge pClk);
            found = baud_tick;
        end
        gap = 0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge pClk);
            gap++;
            found = baud_tick;
        end
        expectEq(tag, gap, exp);
    endtask

    initial begin
        logic [7:0] d;
        int starts, ticks;

        // Reset values
        #12;
        expectEq("rst_irq", irq, 0);
        expectEq("rst_outs", {baud_tick, tx_start, rx_en, tx_frame}, 0);
        @(negedge pClk); pReset = 1'b0;

        @(negedge pClk);
        pSelect = 1'b1; pWrite = 1'b0; pAddress = 8'd3;
        #1 expectEq("pready_setup", pReady, 0);
        @(negedge pClk); pEnable = 1'b1;
        #1 expectEq("pready_access", pReady, 1);
        expectEq("rst_baud", pRData, 8'h0F);
        @(negedge pClk); pSelect = 1'b0; pEnable = 1'b0;
        readExpect("rst_data", 8'd0, 8'h00);
        readExpect("rst_status", 8'd1, 8'h06);
        readExpect("rst_ctrl", 8'd2, 8'h00);
        expectEq("rst_irq_idle", irq, 0);

        // Basic transmit of 0xA5 with divisor 3
        apbWrite(8'd2, 8'h09);
        apbWrite(8'd3, 8'h03);
        apbWrite(8'd0, 8'hA5);
        waitTxStart("tx_a5");
        expectEq("tx_a5_frame", tx_frame, 11'b1_0_10100101_0);
        @(negedge pClk);
        expectEq("tx_start_width", tx_start, 0);
        readExpect("tx_busy_status", 8'd1, 8'h02);
        measureBaud("baud_period", 4);
        pulseTxDone();
        readExpect("tx_done_status", 8'd1, 8'h06);

        // THR overrun while serializer busy
        apbWrite(8'd0, 8'h11);
        waitTxStart("tx_11");
        apbWrite(8'd0, 8'h22);
        apbWrite(8'd0, 8'h33);
        readExpect("tx_ovf_status", 8'd1, 8'h40);
        expectEq("tx_ovf_irq", irq, 1);
        apbWrite(8'd1, 8'h40);
        readExpect("tx_ovf_clr", 8'd1, 8'h00);
        pulseTxDone();
        waitTxStart("tx_22");
        expectEq("tx_22_frame", tx_frame, 11'b1_0_00100010_0);
        pulseTxDone();
        starts = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge pClk);
            if (tx_start) starts++;
        end
        expectEq("tx_33_dropped", starts, 0);
        readExpect("tx_idle_status", 8'd1, 8'h06);

        // Receive, overrun, read-clear
        apbWrite(8'd2, 8'h05);
        expectEq("rx_en_on", rx_en, 1);
        pulseRx(11'b1_0_01010101_0);
        readExpect("rx_first_status", 8'd1, 8'h07);
        pulseRx(11'b1_0_00111100_0);
        readExpect("rx_ovr_status", 8'd1, 8'h0F);
        readExpect("rx_rbr_kept", 8'd0, 8'h55);
        readExpect("rx_read_clr", 8'd1, 8'h0E);
        apbWrite(8'd1, 8'h08);
        readExpect("rx_ovr_clr", 8'd1, 8'h06);

        // Parity/framing errors with odd parity, then read coincident with new frame
        apbWrite(8'd2, 8'h07);
        pulseRx(11'b0_0_10000001_0);
        expectEq("irq_lag", irq, 0);
        @(negedge pClk);
        expectEq("irq_err", irq, 1);
        readExpect("err_status", 8'd1, 8'h37);
        @(negedge pClk);
        pSelect = 1'b1; pWrite = 1'b0; pAddress = 8'd0;
        @(negedge pClk);
        pEnable = 1'b1; rx_valid = 1'b1; rx_frame = 11'b1_1_01000010_0;
        #1 expectEq("rd_coincident_old", pRData, 8'h81);
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0; rx_valid = 1'b0;
        readExpect("rd_coincident_status", 8'd1, 8'h37);
        readExpect("rd_coincident_new", 8'd0, 8'h42);
        apbWrite(8'd1, 8'h78);
        readExpect("err_clr", 8'd1, 8'h06);

        // Disable mid-frame, pending byte restarts after re-enable
        apbWrite(8'd2, 8'h09);
        apbWrite(8'd0, 8'h11);
        waitTxStart("tx_dis");
        expectEq("tx_dis_frame", tx_frame, 11'b1_0_00010001_0);
        apbWrite(8'd2, 8'h00);
        apbWrite(8'd0, 8'h5A);
        expectEq("tx_frame_held", tx_frame, 11'b1_0_00010001_0);
        starts = 0;
        ticks = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge pClk);
            if (tx_start) starts++;
            if (baud_tick) ticks++;
        end
        expectEq("dis_no_start", starts, 0);
        expectEq("dis_no_tick", ticks, 0);
        readExpect("dis_status", 8'd1, 8'h00);
        apbWrite(8'd2, 8'h09);
        waitTxStart("tx_reen");
        expectEq("tx_reen_frame", tx_frame, 11'b1_0_01011010_0);

        // Asynchronous reset mid-frame
        pReset = 1'b1;
        #1;
        expectEq("arst_outs", {tx_start, baud_tick, rx_en, irq, pRData, tx_frame}, 0);
        @(negedge pClk); pReset = 1'b0;
        readExpect("arst_status", 8'd1, 8'h06);
        readExpect("arst_ctrl", 8'd2, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
